// File: rtl/bcd_pkg.sv
// Shared BCD constants and digit helpers for the multi-decade up/down counter.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Digits above 9 saturate to 9 so the count never holds a non-BCD code.
  function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: combinational +1/-1 with carry/borrow ripple to the next decade.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       up_i,
  input  logic       step_i,
  output bcd_digit_t digit_o,
  output logic       step_o
);

  always_comb begin
    digit_o = digit_i;
    step_o  = 1'b0;
    if (step_i) begin
      if (up_i) begin
        if (digit_i == BCD_MAX_DIGIT) begin
          digit_o = '0;
          step_o  = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == '0) begin
          digit_o = BCD_MAX_DIGIT;
          step_o  = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with validated parallel load and wrap/saturate boundary mode.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  rollover,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  load_err
);

  localparam int unsigned W = BCD_W * DIGITS;

  logic [W-1:0]      count_q, count_d;
  logic [W-1:0]      stepped;
  logic [W-1:0]      clamped;
  logic [DIGITS:0]   step;
  logic [DIGITS-1:0] digit_bad;
  logic [DIGITS-1:0] digit_max;
  logic              rollover_q, rollover_d;
  logic              load_err_q, load_err_d;

  // Digit 0 always steps; a ripple out of the top digit marks a boundary.
  assign step[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .digit_i (count_q[BCD_W*i +: BCD_W]),
      .up_i    (up),
      .step_i  (step[i]),
      .digit_o (stepped[BCD_W*i +: BCD_W]),
      .step_o  (step[i+1])
    );

    assign digit_bad[i] = load_val[BCD_W*i +: BCD_W] > BCD_MAX_DIGIT;
    assign clamped[BCD_W*i +: BCD_W] = clamp_digit(load_val[BCD_W*i +: BCD_W]);
    assign digit_max[i] = count_q[BCD_W*i +: BCD_W] == BCD_MAX_DIGIT;
  end

  always_comb begin
    count_d    = count_q;
    rollover_d = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      count_d    = clamped;
      load_err_d = |digit_bad;
    end else if (en) begin
      rollover_d = step[DIGITS];
      // Wrap comes for free from the ripple; saturate just refuses the boundary step.
      if (!(SATURATE && step[DIGITS])) begin
        count_d = stepped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign rollover = rollover_q;
  assign load_err = load_err_q;
  assign at_max   = &digit_max;
  assign at_min   = (count_q == '0);

endmodule
